// File: rtl/am_demod_pkg.sv
// Shared widths and helpers for the coherent AM demodulator.
// Optional DC-removal stage is built only when AM_DEMOD_DCBLOCK_EN is defined.
package am_demod_pkg;

    localparam int SAMPLE_W = 8;
    localparam int PROD_W   = 16;
    localparam int OUT_W    = 16;

    // Clamp a one-bit-wider signed value into the OUT_W signed range.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [OUT_W:0] x);
        if (x[OUT_W] != x[OUT_W-1])
            return x[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        return x[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/am_demod_integ_dump.sv
// Integrate-and-dump decimator: sums 2^DEC_LOG2 valid inputs, emits their floored mean
// with a one-cycle strobe, then restarts from zero.
module integ_dump #(
    parameter int DEC_LOG2 = 6,
    parameter int IN_W     = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr,
    input  logic signed [IN_W-1:0] i_prod,
    input  logic                   i_prod_v,
    output logic signed [IN_W-1:0] o_result,
    output logic                   o_strobe
);

    localparam int ACC_W = IN_W + DEC_LOG2;

    logic signed [ACC_W-1:0]    r_acc;
    logic        [DEC_LOG2-1:0] r_cnt;
    logic signed [ACC_W-1:0]    w_sum;

    // Accumulator is wide enough for a full frame of worst-case inputs, so no wrap.
    assign w_sum = r_acc + ACC_W'(i_prod);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            o_result <= '0;
            o_strobe <= 1'b0;
        end else if (clr) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            o_strobe <= 1'b0;
        end else begin
            o_strobe <= 1'b0;
            if (i_prod_v) begin
                if (&r_cnt) begin
                    o_result <= IN_W'(w_sum >>> DEC_LOG2);
                    o_strobe <= 1'b1;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/am_demod.sv
// Coherent AM demodulator: multiply by carrier, integrate-and-dump, optional DC removal.
// Define AM_DEMOD_DCBLOCK_EN to insert the DC-tracking stage (one extra cycle of latency).
import am_demod_pkg::*;

module am_demod #(
    parameter int DEC_LOG2 = 6,
    parameter int DC_SHIFT = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clr,
    input  logic signed [SAMPLE_W-1:0] am_in,
    input  logic                       am_valid,
    input  logic signed [SAMPLE_W-1:0] carrier_ref,
    output logic signed [OUT_W-1:0]    demod_out,
    output logic                       demod_valid
);

    if (DEC_LOG2 < 1 || DEC_LOG2 > 10 || DC_SHIFT < 1) begin : g_bad_param
        $error("am_demod: DEC_LOG2 must be 1..10 and DC_SHIFT >= 1");
    end

    logic signed [PROD_W-1:0] r_prod;
    logic                     r_prod_v;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [OUT_W-1:0]  w_result;
    logic                     w_strobe;
    logic signed [OUT_W-1:0]  w_out;
    logic                     w_out_v;

    assign w_prod = PROD_W'(am_in) * PROD_W'(carrier_ref);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prod   <= '0;
            r_prod_v <= 1'b0;
        end else if (clr) begin
            r_prod_v <= 1'b0;
        end else begin
            r_prod_v <= am_valid;
            if (am_valid) r_prod <= w_prod;
        end
    end

    integ_dump #(
        .DEC_LOG2 (DEC_LOG2),
        .IN_W     (PROD_W)
    ) u_integ (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .i_prod   (r_prod),
        .i_prod_v (r_prod_v),
        .o_result (w_result),
        .o_strobe (w_strobe)
    );

`ifdef AM_DEMOD_DCBLOCK_EN
    localparam int EST_W = OUT_W + DC_SHIFT;

    logic signed [EST_W-1:0] r_est;
    logic signed [OUT_W-1:0] r_y;
    logic                    r_y_v;
    logic signed [OUT_W-1:0] w_mean;
    logic signed [OUT_W:0]   w_diff;

    assign w_mean = OUT_W'(r_est >>> DC_SHIFT);
    assign w_diff = (OUT_W+1)'(w_result) - (OUT_W+1)'(w_mean);

    // Leaky tracker: est settles at 2^DC_SHIFT times the running DC level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_est <= '0;
            r_y   <= '0;
            r_y_v <= 1'b0;
        end else if (clr) begin
            r_est <= '0;
            r_y_v <= 1'b0;
        end else begin
            r_y_v <= w_strobe;
            if (w_strobe) begin
                r_y   <= sat_out(w_diff);
                r_est <= r_est + EST_W'(w_diff);
            end
        end
    end

    assign w_out   = r_y;
    assign w_out_v = r_y_v;
`else
    assign w_out   = w_result;
    assign w_out_v = w_strobe;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            demod_out   <= '0;
            demod_valid <= 1'b0;
        end else if (clr) begin
            demod_valid <= 1'b0;
        end else begin
            demod_valid <= w_out_v;
            if (w_out_v) demod_out <= w_out;
        end
    end

endmodule

// File: doc/am_demod.md
# am_demod

Coherent AM demodulator: the receive end of the DDS signal maker. Each accepted signed 8-bit AM sample is multiplied by a local carrier reference. The product is low-pass filtered and decimated with an integrate-and-dump stage over 2^DEC_LOG2 samples. The result is the recovered baseband as a signed 16-bit sample with a one-cycle valid strobe, ready for display or loopback comparison against the modulating signal.

## Interface
Parameters:
- DEC_LOG2, 6: log2 of samples per output (decimation 2^DEC_LOG2); legal 1..10.
- DC_SHIFT, 4: DC-tracker time constant (shift); used only with the macro enabled.

Ports:
- clk  in  1  system clock; one clock domain.
- rstn  in  1  reset, asynchronous and active-low.
- clr  in  1  synchronous frame restart; flushes pipeline, counter, accumulator and DC estimate.
- am_in  in  8  signed AM sample.
- am_valid  in  1  am_in/carrier_ref valid this cycle.
- carrier_ref  in  8  signed local carrier, phase-aligned with am_in.
- demod_out  out  16  signed recovered baseband, held between strobes.
- demod_valid  out  1  one-cycle strobe per new demod_out.

## Operation
- Stage 1 (multiply): on am_valid, prod <= am_in * carrier_ref, signed 16-bit; prod_v <= am_valid.
  - Range -16256..+16384; +16384 occurs only at -128 x -128 and fits in 16-bit signed.
- Stage 2 (integrate-and-dump):
  - acc is signed (16+DEC_LOG2) bits and never overflows.
  - cnt is DEC_LOG2 bits and counts prod_v cycles.
  - On prod_v with cnt != 2^DEC_LOG2-1: acc <= acc+prod, cnt <= cnt+1.
  - On prod_v with cnt == 2^DEC_LOG2-1: result <= (acc+prod) >>> DEC_LOG2 (arithmetic, truncating toward -inf), strobe; acc <= 0, cnt <= 0.
- Output: demod_out <= result and demod_valid <= 1 on the strobe; otherwise demod_valid <= 0 and demod_out holds.
- Gaps in am_valid stall the frame. No timeout; a partial frame waits indefinitely.
- clr: prod_v, cnt, acc, DC estimate and demod_valid are cleared next edge. demod_out holds.
  - clr with am_valid in the same cycle: clr wins and the sample is dropped.
  - clr coincident with a dump: no strobe.
- Reset (rstn low, any time including mid-frame): demod_out=0, demod_valid=0, prod=0, prod_v=0, acc=0, cnt=0, DC estimate=0. All take effect immediately and asynchronously.

## Timing
- Throughput: one sample per clock.
- Latency: last sample of a frame accepted at edge t gives demod_valid high for exactly the cycle after edge t+2. With the macro enabled, it is t+3.
- Strobes are spaced at least 2^DEC_LOG2 cycles apart.

## Configuration
- Macro: AM_DEMOD_DCBLOCK_EN.
- Defined: a DC-removal stage sits after the dump.
  - Tracker est is signed (16+DC_SHIFT) bits, reset 0.
  - On each dump: mean = est >>> DC_SHIFT; y = result - mean, saturated to [-32768, 32767]; est <= est + result - mean.
  - demod_out = y. Adds one cycle of latency.
- Undefined: demod_out = result directly. No tracker registers exist; DC_SHIFT is ignored.

## Structure
- Package am_demod_pkg: SAMPLE_W=8, PROD_W=16, OUT_W=16, and a saturate-to-OUT_W function.
- Sub-module integ_dump: the cnt/acc/dump logic, parameterised by DEC_LOG2 and input width. It takes prod, prod_v and clr, and returns result and a strobe.
- The top level holds the multiplier register, the optional DC stage and the output registers.

## Test plan
Directed tests use DEC_LOG2=2 and run with the macro undefined unless noted.
- Constant am_in=64, carrier_ref=64, am_valid=1 → demod_out=4096, demod_valid once per 4 samples, first strobe 2 cycles after the 4th sample edge.
- am_in=-128, carrier_ref=-128 constant → demod_out=16384, no wrap.
- am_in=100, carrier_ref alternating +100/-100 → demod_out=0 every frame.
- am_valid toggled 1/0/0/1 with am_in=carrier_ref=10 → strobe only after 4 accepted samples; demod_out=100; output held between strobes.
- Two samples of 50x50, clr pulse, then four samples of 10x10 → single strobe with demod_out=100. clr asserted together with am_valid drops that sample.
- rstn low mid-frame → demod_out=0, demod_valid=0 immediately. Next full frame of 64x64 gives 4096.
  - With AM_DEMOD_DCBLOCK_EN and DC_SHIFT=4, constant 4096 input gives successive outputs 4096, 3840, 3600..., decaying toward 0; latency 3 cycles.
